// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmitter and receiver: frame state
// encodings, data width and the parity helper. Both directions use the same
// state numbering so traces from either side read the same way.
// -----------------------------------------------------------------------------
package uart_pkg;

   localparam int unsigned DATA_BITS = 8;

   typedef enum logic [2:0] {
      StIdle    = 3'd0,
      StStart   = 3'd1,
      StData    = 3'd2,
      StParity  = 3'd3,
      StStop    = 3'd4,
      StCleanup = 3'd5
   } uart_state_e;

   // Parity bit for a data word: even parity when i_odd=0, odd when i_odd=1.
   function automatic logic calc_parity(input logic [DATA_BITS-1:0] i_data,
                                        input logic                 i_odd);
      return (^i_data) ^ i_odd;
   endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// -----------------------------------------------------------------------------
// uart_bit_timer
// Free-running bit-period counter. Counts 0..CLK_PER_BIT-1 and flags the final
// cycle of the bit period; the owner clears it at every bit boundary and while
// no frame is in progress.
//
// Ports:
//   i_clk        system clock, rising edge
//   i_rst_n      asynchronous active-low reset
//   i_clear      synchronous clear of the counter to zero
//   o_last_cycle high while the counter holds CLK_PER_BIT-1
// -----------------------------------------------------------------------------
module uart_bit_timer #(
   parameter int unsigned CLK_PER_BIT = 87
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_clear,
   output logic o_last_cycle
);

   localparam int unsigned CNT_W = $clog2(CLK_PER_BIT);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLK_PER_BIT - 1);

   logic [CNT_W-1:0] r_count;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_count <= '0;
      end else if (i_clear) begin
         r_count <= '0;
      end else begin
         r_count <= r_count + CNT_W'(1);
      end
   end

   assign o_last_cycle = (r_count == LAST_CNT);

endmodule

// File: rtl/uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx
// UART transmitter: serialises one byte per accepted request into a frame of
// start bit, 8 data bits LSB first, optional parity bit and one stop bit, each
// held CLK_PER_BIT clocks. One frame in flight; requests outside IDLE are
// ignored. All outputs are registered.
//
// Ports:
//   i_clk       system clock, rising edge
//   i_rst_n     asynchronous active-low reset (aborts any frame, line high)
//   i_tx_dv     request strobe, accepted only when sampled high in IDLE
//   i_tx_byte   byte to send, captured on the accept cycle
//   o_tx_active high from the first start-bit cycle through the last stop cycle
//   o_tx_serial serial line, idle high
//   o_tx_done   one-cycle pulse after the stop bit completes
// -----------------------------------------------------------------------------
module uart_tx
   import uart_pkg::*;
#(
   parameter int unsigned CLK_PER_BIT = 87,
   parameter bit          PARITY_EN   = 1'b0,
   parameter bit          PARITY_ODD  = 1'b0
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic                 i_tx_dv,
   input  logic [DATA_BITS-1:0] i_tx_byte,
   output logic                 o_tx_active,
   output logic                 o_tx_serial,
   output logic                 o_tx_done
);

   localparam logic [2:0] LAST_BIT_IDX = 3'(DATA_BITS - 1);

   uart_state_e          r_state;
   logic [DATA_BITS-1:0] r_shift;
   logic [2:0]           r_bit_idx;
   logic                 r_parity;
   logic                 r_tx_serial;
   logic                 r_tx_active;
   logic                 r_tx_done;

   logic w_last;
   logic w_clear;

   // Hold the timer at zero outside the bit-timed states so every START begins
   // a full bit period; clearing on the last cycle starts the next period at 0.
   assign w_clear = (r_state == StIdle) || (r_state == StCleanup) || w_last;

   uart_bit_timer #(
      .CLK_PER_BIT(CLK_PER_BIT)
   ) u_bit_timer (
      .i_clk       (i_clk),
      .i_rst_n     (i_rst_n),
      .i_clear     (w_clear),
      .o_last_cycle(w_last)
   );

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state     <= StIdle;
         r_shift     <= '0;
         r_bit_idx   <= '0;
         r_parity    <= 1'b0;
         r_tx_serial <= 1'b1;
         r_tx_active <= 1'b0;
         r_tx_done   <= 1'b0;
      end else begin
         r_tx_done <= 1'b0;
         case (r_state)
            StIdle: begin
               r_tx_serial <= 1'b1;
               r_tx_active <= 1'b0;
               r_bit_idx   <= '0;
               if (i_tx_dv) begin
                  r_shift     <= i_tx_byte;
                  r_parity    <= calc_parity(i_tx_byte, PARITY_ODD);
                  r_tx_serial <= 1'b0;
                  r_tx_active <= 1'b1;
                  r_state     <= StStart;
               end
            end
            StStart: begin
               if (w_last) begin
                  // Shift register always presents the next data bit at [0].
                  r_tx_serial <= r_shift[0];
                  r_shift     <= r_shift >> 1;
                  r_state     <= StData;
               end
            end
            StData: begin
               if (w_last) begin
                  if (r_bit_idx == LAST_BIT_IDX) begin
                     if (PARITY_EN) begin
                        r_tx_serial <= r_parity;
                        r_state     <= StParity;
                     end else begin
                        r_tx_serial <= 1'b1;
                        r_state     <= StStop;
                     end
                  end else begin
                     r_bit_idx   <= r_bit_idx + 3'd1;
                     r_tx_serial <= r_shift[0];
                     r_shift     <= r_shift >> 1;
                  end
               end
            end
            StParity: begin
               if (w_last) begin
                  r_tx_serial <= 1'b1;
                  r_state     <= StStop;
               end
            end
            StStop: begin
               if (w_last) begin
                  r_tx_serial <= 1'b1;
                  r_tx_active <= 1'b0;
                  r_tx_done   <= 1'b1;
                  r_state     <= StCleanup;
               end
            end
            StCleanup: begin
               r_tx_serial <= 1'b1;
               r_tx_active <= 1'b0;
               r_state     <= StIdle;
            end
            default: begin
               r_tx_serial <= 1'b1;
               r_tx_active <= 1'b0;
               r_state     <= StIdle;
            end
         endcase
      end
   end

   assign o_tx_active = r_tx_active;
   assign o_tx_serial = r_tx_serial;
   assign o_tx_done   = r_tx_done;

endmodule

// File: tb/tb_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_uart_tx
// Five transmitter configurations share one byte bus; sel routes the request
// strobe to one instance and muxes its outputs to a frame monitor. Stimulus
// pushes hand-computed frames (symbol i of the frame at bit i, start first) to
// a scoreboard; the monitor captures every frame cycle by cycle and compares
// symbol values, symbol length, active window, done pulse and inter-frame gap.
// -----------------------------------------------------------------------------
module tb_uart_tx;

   typedef struct {
      logic [10:0] bits;
      int          nsym;
      int          gap;   // expected idle samples before this frame, -1 = any
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       dv;
   logic [7:0] tx_byte;
   int         sel;

   logic ser    [5];
   logic act    [5];
   logic done_o [5];

   logic m_ser, m_act, m_done;
   int   cur_n, cur_f;

   int errors = 0;
   int checks = 0;

   exp_t sb_q[$];

   always #5 clk = ~clk;

   uart_tx #(.CLK_PER_BIT(4), .PARITY_EN(1'b0), .PARITY_ODD(1'b0)) u_dut_n4 (
      .i_clk(clk), .i_rst_n(rst_n), .i_tx_dv(dv && (sel == 0)), .i_tx_byte(tx_byte),
      .o_tx_active(act[0]), .o_tx_serial(ser[0]), .o_tx_done(done_o[0]));
   uart_tx #(.CLK_PER_BIT(4), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) u_dut_even (
      .i_clk(clk), .i_rst_n(rst_n), .i_tx_dv(dv && (sel == 1)), .i_tx_byte(tx_byte),
      .o_tx_active(act[1]), .o_tx_serial(ser[1]), .o_tx_done(done_o[1]));
   uart_tx #(.CLK_PER_BIT(4), .PARITY_EN(1'b1), .PARITY_ODD(1'b1)) u_dut_odd (
      .i_clk(clk), .i_rst_n(rst_n), .i_tx_dv(dv && (sel == 2)), .i_tx_byte(tx_byte),
      .o_tx_active(act[2]), .o_tx_serial(ser[2]), .o_tx_done(done_o[2]));
   uart_tx #(.CLK_PER_BIT(2), .PARITY_EN(1'b0), .PARITY_ODD(1'b0)) u_dut_n2 (
      .i_clk(clk), .i_rst_n(rst_n), .i_tx_dv(dv && (sel == 3)), .i_tx_byte(tx_byte),
      .o_tx_active(act[3]), .o_tx_serial(ser[3]), .o_tx_done(done_o[3]));
   uart_tx #(.CLK_PER_BIT(87), .PARITY_EN(1'b0), .PARITY_ODD(1'b0)) u_dut_n87 (
      .i_clk(clk), .i_rst_n(rst_n), .i_tx_dv(dv && (sel == 4)), .i_tx_byte(tx_byte),
      .o_tx_active(act[4]), .o_tx_serial(ser[4]), .o_tx_done(done_o[4]));

   always_comb begin
      m_ser  = 1'b1;
      m_act  = 1'b0;
      m_done = 1'b0;
      cur_n  = 4;
      cur_f  = 10;
      case (sel)
         0: begin m_ser = ser[0]; m_act = act[0]; m_done = done_o[0]; cur_n = 4;  cur_f = 10; end
         1: begin m_ser = ser[1]; m_act = act[1]; m_done = done_o[1]; cur_n = 4;  cur_f = 11; end
         2: begin m_ser = ser[2]; m_act = act[2]; m_done = done_o[2]; cur_n = 4;  cur_f = 11; end
         3: begin m_ser = ser[3]; m_act = act[3]; m_done = done_o[3]; cur_n = 2;  cur_f = 10; end
         4: begin m_ser = ser[4]; m_act = act[4]; m_done = done_o[4]; cur_n = 87; cur_f = 10; end
         default: ;
      endcase
   end

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got=%0h want=%0h (t=%0t)", nm, got, want, $time);
      end
   endtask

   // ---------------------------------------------------------------- monitor
   logic cap_ser  [0:1023];
   logic cap_act  [0:1023];
   logic cap_done [0:1023];

   initial begin : monitor
      logic        prev_act;
      int          idle_run;
      int          total;
      int          n;
      int          gap_seen;
      logic        aborted;
      logic        bits_ok, act_ok, done_ok;
      logic [10:0] obs;
      exp_t        e;
      prev_act = 1'b0;
      idle_run = 0;
      forever begin
         @(posedge clk);
         #1;
         if (!rst_n) begin
            prev_act = 1'b0;
            idle_run = 0;
         end else if (m_act && !prev_act) begin
            gap_seen = idle_run;
            n        = cur_n;
            total    = cur_f * cur_n;
            cap_ser[0]  = m_ser;
            cap_act[0]  = m_act;
            cap_done[0] = m_done;
            aborted = 1'b0;
            for (int j = 1; j <= total; j++) begin
               @(posedge clk);
               #1;
               if (!rst_n) begin
                  aborted = 1'b1;
                  break;
               end
               cap_ser[j]  = m_ser;
               cap_act[j]  = m_act;
               cap_done[j] = m_done;
            end
            if (!aborted) begin
               if (sb_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_frame: got a frame, want none (t=%0t)", $time);
               end else begin
                  e = sb_q.pop_front();
                  bits_ok = (e.nsym == cur_f);
                  obs = '0;
                  for (int s = 0; s < cur_f; s++) begin
                     obs[s] = cap_ser[s * n];
                     for (int c = 0; c < n; c++) begin
                        if (cap_ser[s * n + c] !== e.bits[s]) bits_ok = 1'b0;
                     end
                  end
                  checks++;
                  if (!bits_ok) begin
                     errors++;
                     $display("FAIL frame_bits sel=%0d: got=%h want=%h", sel, obs, e.bits);
                  end
                  act_ok = (cap_act[total] === 1'b0);
                  for (int j = 0; j < total; j++) begin
                     if (cap_act[j] !== 1'b1 || cap_done[j] !== 1'b0) act_ok = 1'b0;
                  end
                  checks++;
                  if (!act_ok) begin
                     errors++;
                     $display("FAIL active_window sel=%0d: active not exactly %0d cycles", sel,
                              total);
                  end
                  done_ok = (cap_done[total] === 1'b1) && (cap_ser[total] === 1'b1);
                  checks++;
                  if (!done_ok) begin
                     errors++;
                     $display("FAIL done_pulse sel=%0d: done=%b serial=%b want 1 1", sel,
                              cap_done[total], cap_ser[total]);
                  end
                  if (e.gap >= 0) chk("b2b_gap", gap_seen, e.gap);
               end
            end
            prev_act = 1'b0;
            idle_run = 0;
         end else begin
            if (m_done) begin
               checks++;
               errors++;
               $display("FAIL stray_done sel=%0d: got done=1 want 0 (t=%0t)", sel, $time);
            end
            if (!m_act) idle_run++;
            prev_act = m_act;
         end
      end
   end

   // --------------------------------------------------------------- stimulus
   task automatic push(input logic [10:0] b, input int ns, input int g);
      sb_q.push_back('{bits: b, nsym: ns, gap: g});
   endtask

   // Holds the request until the transmitter shows active, then drops it.
   task automatic send(input logic [7:0] b);
      logic seen;
      seen = 1'b0;
      @(negedge clk);
      tx_byte = b;
      dv      = 1'b1;
      for (int k = 0; k < 50; k++) begin
         @(posedge clk);
         #1;
         if (m_act) begin
            seen = 1'b1;
            break;
         end
      end
      if (!seen) chk("accept_timeout", 32'(seen), 32'd1);
      @(negedge clk);
      dv = 1'b0;
   endtask

   task automatic wait_done(input int limit);
      logic seen;
      seen = 1'b0;
      for (int k = 0; k < limit; k++) begin
         @(posedge clk);
         #1;
         if (m_done) begin
            seen = 1'b1;
            break;
         end
      end
      if (!seen) chk("done_timeout", 32'(seen), 32'd1);
   endtask

   task automatic back_to_back(input int s, input logic [10:0] fr);
      int   rises;
      logic prev;
      sel = s;
      push(fr, 10, -1);
      push(fr, 10, 1);
      push(fr, 10, 1);
      rises = 0;
      prev  = 1'b0;
      @(negedge clk);
      tx_byte = 8'hF0;
      dv      = 1'b1;
      for (int k = 0; k < 400; k++) begin
         @(posedge clk);
         #1;
         if (m_act && !prev) rises++;
         prev = m_act;
         if (rises == 3) break;
      end
      if (rises != 3) chk("b2b_starts", 32'(rises), 32'd3);
      @(negedge clk);
      dv = 1'b0;
      wait_done(200);
   endtask

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      rst_n   = 1'b0;
      dv      = 1'b0;
      tx_byte = 8'h00;
      sel     = 0;
      repeat (3) @(negedge clk);
      chk("reset_serial", 32'(ser[0]), 32'd1);
      chk("reset_active", 32'(act[0]), 32'd0);
      chk("reset_done",   32'(done_o[0]), 32'd0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Basic frame, A5 at N=4.
      push(11'h34A, 10, -1);
      send(8'hA5);
      wait_done(100);

      // Mid-frame reset during data bit 3 (a 0 for A5), then a clean frame.
      send(8'hA5);
      repeat (17) @(posedge clk);
      #2;
      chk("pre_reset_active", 32'(m_act), 32'd1);
      chk("pre_reset_bit3",   32'(m_ser), 32'd0);
      rst_n = 1'b0;
      #1;
      chk("midrst_serial", 32'(m_ser), 32'd1);
      chk("midrst_active", 32'(m_act), 32'd0);
      chk("midrst_done",   32'(m_done), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      push(11'h278, 10, -1);
      send(8'h3C);
      wait_done(100);

      // Parity: 07 has three ones -> even parity bit 1, odd parity bit 0.
      sel = 1;
      push(11'h60E, 11, -1);
      send(8'h07);
      wait_done(100);
      sel = 2;
      push(11'h40E, 11, -1);
      send(8'h07);
      wait_done(100);

      // Busy-ignore: second request lands in DATA and must be dropped.
      sel = 0;
      repeat (3) @(negedge clk);
      push(11'h224, 10, -1);
      send(8'h12);
      repeat (8) @(negedge clk);
      tx_byte = 8'h34;
      dv      = 1'b1;
      @(negedge clk);
      dv = 1'b0;
      wait_done(100);
      repeat (10) @(negedge clk);

      // Back-to-back with request held, N=4 then N=2.
      back_to_back(0, 11'h3E0);
      repeat (5) @(negedge clk);
      back_to_back(3, 11'h3E0);
      repeat (5) @(negedge clk);

      // N=87 byte stream.
      sel = 4;
      push(11'h200, 10, -1);
      send(8'h00);
      wait_done(2000);
      push(11'h3FE, 10, -1);
      send(8'hFF);
      wait_done(2000);
      push(11'h2AA, 10, -1);
      send(8'h55);
      wait_done(2000);
      push(11'h302, 10, -1);
      send(8'h81);
      wait_done(2000);

      repeat (20) @(negedge clk);
      chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- UART transmitter that serialises one byte per request into an 8N1 frame (optional parity) at a fixed clocks-per-bit rate.
- It is the transmit counterpart of the existing UART receiver and uses the same clocks-per-bit convention, so the two loop back directly.
- Sits between the byte-producing logic (host/FIFO) and the serial TX pin; one frame in flight at a time, with a valid/active/done handshake.

Parameters:
- CLK_PER_BIT, 87, i_clk cycles per serial bit (e.g. 10 MHz / 115200); legal range 2..65535.
- PARITY_EN, 0, 1 = insert a parity bit between d7 and the stop bit.
- PARITY_ODD, 0, 1 = odd parity, 0 = even; ignored when PARITY_EN=0.

Ports:
- i_clk  in  1  system clock, all logic on rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_tx_dv  in  1  request strobe; byte accepted only when sampled high in IDLE.
- i_tx_byte  in  8  data to send; captured on the accept cycle.
- o_tx_active  out  1  high from the first start-bit cycle through the last stop-bit cycle.
- o_tx_serial  out  1  serial line, registered, idle high.
- o_tx_done  out  1  one-cycle pulse after the stop bit completes.

Behaviour:
- Reset (async assert, sync-released internally by i_rst_n deassert edge) sets: o_tx_serial=1, o_tx_active=0, o_tx_done=0, state=IDLE, counters=0, shift register=0.
- Reset mid-frame aborts immediately and the line returns high. No partial-frame recovery.
- States and transitions:
  - IDLE: serial=1, active=0, done=0. On i_tx_dv=1: latch i_tx_byte, compute parity, go to START.
  - START: serial=0 for CLK_PER_BIT cycles, then go to DATA.
  - DATA: bit index 0..7, LSB first; each bit held CLK_PER_BIT cycles. After bit 7, go to PARITY if PARITY_EN, else STOP.
  - PARITY: serial = XOR of the byte, XORed with PARITY_ODD; held CLK_PER_BIT cycles, then go to STOP.
  - STOP: serial=1 for CLK_PER_BIT cycles, then go to CLEANUP.
  - CLEANUP: one cycle with done=1, active=0, serial=1, then go to IDLE.
  - Any illegal state encoding goes to IDLE.
- Timing, with accept at cycle 0 and N=CLK_PER_BIT, F=10 (11 with parity):
  - Start bit occupies cycles 1..N; active rises at cycle 1.
  - Bit k occupies cycles 1+(k+1)N .. (k+2)N.
  - Stop bit occupies cycles (F-1)N+1 .. FN.
  - o_tx_done=1 at cycle FN+1.
  - Back in IDLE at FN+2; earliest next accept is cycle FN+2, giving a gap of one extra idle-high cycle plus CLEANUP.
- Bit counter counts 0..N-1 with width $clog2(CLK_PER_BIT) and clears at each bit boundary. Bit index is 3 bits and does not wrap past 7.
- i_tx_dv and i_tx_byte are ignored outside IDLE. Changing i_tx_byte mid-frame does not affect the frame.
- i_tx_dv held continuously yields back-to-back frames separated by 2 clock cycles (CLEANUP + IDLE).
- All outputs are registered; no combinational path from inputs to outputs.

Decomposition:
- Shared package uart_pkg holds:
  - state encodings: IDLE=3'd0, START=3'd1, DATA=3'd2, PARITY=3'd3, STOP=3'd4, CLEANUP=3'd5 (the receiver migrates to the same encodings);
  - a DATA_BITS=8 constant;
  - a parity function.
- One natural sub-module, uart_bit_timer: counter of width $clog2(CLK_PER_BIT) with clear input and a last_cycle output. It is reusable by the receiver. Everything else stays flat.

Test Plan:
- Reset: hold i_rst_n=0 mid-frame, N=4, byte 8'hA5 at bit 3 -> serial=1, active=0, done=0 in the same cycle; after release, a new byte 8'h3C transmits cleanly.
- Basic frame, N=4, PARITY_EN=0, send 8'hA5 -> line reads 0,1,0,1,0,0,1,0,1,1, each symbol held 4 cycles; active high cycles 1..40; done pulse at cycle 41 only.
- Loopback: uart_tx to uart_rx, N=87, bytes 8'h00, 8'hFF, 8'h55, 8'h81 -> receiver outputs identical bytes in order, no framing error.
- Parity, N=4, PARITY_EN=1: byte 8'h07 with even parity -> parity bit 1; same byte with PARITY_ODD=1 -> parity bit 0; frame is 44 active cycles.
- Busy-ignore: pulse i_tx_dv with 8'h12, then pulse again with 8'h34 during DATA -> only 8'h12 is sent; one done pulse.
- Back-to-back: hold i_tx_dv=1 with 8'hF0 -> next start bit falls exactly 2 cycles after the previous stop bit ends; N=2 boundary case verified.
